jtag_debug_cmd_bridge: RTL

Parametrised system-clock half of the CPU JTAG debug channel. Takes the update-DR/update-IR strobes and the captured IR/DR words from the TCK-domain shift logic, synchronises the strobes into `clk`, queues each completed DR scan in a small FIFO, and hands commands to the CPU debug logic. Each command is exposed as a held data word plus a one-cycle per-instruction action/no-action pulse. It generalises IR/DR width and adds queuing, backpressure and overflow reporting.

---
 rtl/jtag_debug_cmd_bridge_if.sv | 33 +++
 rtl/jtag_debug_cmd_bridge.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/jtag_debug_cmd_bridge_if.sv
// Command channel between the JTAG debug bridge and the CPU debug logic.
// The bridge drives the command side (master); the consumer returns cmd_ready (slave).
interface jtag_debug_cmd_bridge_if #(
    parameter int IR_WIDTH = 2,
    parameter int DR_WIDTH = 38
);
    localparam int N_CH = 2 ** IR_WIDTH;

    logic                cmd_valid;
    logic                cmd_ready;
    logic [DR_WIDTH-1:0] jdo;
    logic [IR_WIDTH-1:0] jir;
    logic [N_CH-1:0]     take_action;
    logic [N_CH-1:0]     take_no_action;

    modport master (
        output cmd_valid,
        output jdo,
        output jir,
        output take_action,
        output take_no_action,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  jdo,
        input  jir,
        input  take_action,
        input  take_no_action,
        output cmd_ready
    );
endinterface

// File: rtl/jtag_debug_cmd_bridge.sv
// System-clock half of the JTAG debug channel: synchronises update strobes, queues
// completed DR scans in a first-word-fall-through FIFO and issues per-instruction pulses.
module jtag_debug_cmd_bridge #(
    parameter int IR_WIDTH    = 2,
    parameter int DR_WIDTH    = 38,
    parameter int SYNC_STAGES = 3,
    parameter int FIFO_DEPTH  = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          vs_udr,
    input  logic                          vs_uir,
    input  logic [IR_WIDTH-1:0]           ir_in,
    input  logic [DR_WIDTH-1:0]           sr,
    input  logic                          clear_overflow,
    output logic                          ir_update,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    jtag_debug_cmd_bridge_if.master       cmd_if
);
    localparam int N_CH    = 2 ** IR_WIDTH;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int LVL_W   = PTR_W + 1;
    localparam int ENTRY_W = IR_WIDTH + DR_WIDTH;

    localparam logic [LVL_W-1:0] FULL_LEVEL = LVL_W'(FIFO_DEPTH);
    localparam logic [LVL_W-1:0] LVL_ONE    = LVL_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);
    localparam logic [N_CH-1:0]  CH_ONE     = N_CH'(1);

    logic [SYNC_STAGES-1:0] r_udr_sync;
    logic [SYNC_STAGES-1:0] r_uir_sync;
    logic                   r_udr_dly;
    logic                   r_uir_dly;
    logic                   w_udr_rise;
    logic                   w_uir_rise;

    logic [ENTRY_W-1:0]     r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [LVL_W-1:0]       r_level;
    logic [LVL_W-1:0]       w_level_nxt;

    logic                   w_full;
    logic                   w_cmd_valid;
    logic                   w_pop;
    logic                   w_push_ok;
    logic                   w_drop;
    logic [ENTRY_W-1:0]     w_head;
    logic [IR_WIDTH-1:0]    w_head_ir;
    logic [N_CH-1:0]        w_head_onehot;

    logic [DR_WIDTH-1:0]    r_jdo;
    logic [IR_WIDTH-1:0]    r_jir;
    logic [N_CH-1:0]        r_take_action;
    logic [N_CH-1:0]        r_take_no_action;
    logic                   r_ir_update;
    logic                   r_overflow;

    // Strobe synchronisers; the extra delay flop turns the synchronised level into an edge.
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_udr_sync <= '0;
            r_uir_sync <= '0;
            r_udr_dly  <= 1'b0;
            r_uir_dly  <= 1'b0;
        end else begin
            r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
            r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
            r_udr_dly  <= r_udr_sync[SYNC_STAGES-1];
            r_uir_dly  <= r_uir_sync[SYNC_STAGES-1];
        end
    end

    assign w_udr_rise = r_udr_sync[SYNC_STAGES-1] & ~r_udr_dly;
    assign w_uir_rise = r_uir_sync[SYNC_STAGES-1] & ~r_uir_dly;

    assign w_full      = (r_level == FULL_LEVEL);
    assign w_cmd_valid = (r_level != '0);
    assign w_pop       = w_cmd_valid & cmd_if.cmd_ready;
    // A full queue still accepts a scan when the head leaves in the same cycle.
    assign w_push_ok   = w_udr_rise & (~w_full | w_pop);
    assign w_drop      = w_udr_rise & w_full & ~w_pop;

    assign w_head        = r_mem[r_rd_ptr];
    assign w_head_ir     = w_head[ENTRY_W-1:DR_WIDTH];
    assign w_head_onehot = CH_ONE << w_head_ir;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        w_level_nxt = r_level;
        case ({w_push_ok, w_pop})
            2'b10:   w_level_nxt = r_level + LVL_ONE;
            2'b01:   w_level_nxt = r_level - LVL_ONE;
            default: w_level_nxt = r_level;
        endcase
    end

    // NOTE: the storage array has no reset; occupancy is tracked by the pointers and level only.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= {ir_in, sr};
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
            end
            r_level <= w_level_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_jdo            <= '0;
            r_jir            <= '0;
            r_take_action    <= '0;
            r_take_no_action <= '0;
        end else begin
            r_take_action    <= '0;
            r_take_no_action <= '0;
            if (w_pop) begin
                r_jdo <= w_head[DR_WIDTH-1:0];
                r_jir <= w_head_ir;
                if (w_head[DR_WIDTH-1]) begin
                    r_take_action <= w_head_onehot;
                end else begin
                    r_take_no_action <= w_head_onehot;
                end
            end
        end
    end

    // Sticky drop flag; a drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow  <= 1'b0;
            r_ir_update <= 1'b0;
        end else begin
            r_ir_update <= w_uir_rise;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (clear_overflow) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign cmd_if.cmd_valid      = w_cmd_valid;
    assign cmd_if.jdo            = r_jdo;
    assign cmd_if.jir            = r_jir;
    assign cmd_if.take_action    = r_take_action;
    assign cmd_if.take_no_action = r_take_no_action;

    assign ir_update  = r_ir_update;
    assign fifo_level = r_level;
    assign overflow   = r_overflow;

endmodule
